// File: rtl/fpmul_stream_pkg.sv
// fpmul_stream_pkg
// Shared definitions for the streaming FP multiplier:
//   DEF_W / DEF_LAT / DEF_DEPTH / DEF_TAGW : default parameter values
//   result_t : one output-buffer entry, product plus the tag of its operation
package fpmul_stream_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_LAT   = 4;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_TAGW  = 4;

    typedef struct packed {
        logic [DEF_W-1:0]    z;
        logic [DEF_TAGW-1:0] tag;
    } result_t;

endpackage

// File: rtl/FPmul.sv
// FPmul
// Single-precision IEEE-754 multiplier core, fixed latency, no stall.
// Operands are sampled on every rising edge; the product of the pair sampled
// at edge k is presented on FP_Z after edge k+LAT-1, so a consumer that
// tracks validity separately captures it on edge k+LAT.
// Rounding is round-to-nearest-even; subnormal inputs and results flush to
// signed zero, overflow gives signed infinity, invalid cases give a quiet NaN.
// Ports:
//   clk  : clock
//   FP_A : operand A (32 bits)
//   FP_B : operand B (32 bits)
//   FP_Z : product  (32 bits)
module FPmul #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic [31:0] FP_Z
);

    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic              sign;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic [23:0]       frac_r;
    logic signed [9:0] exp_s;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [31:0]       z_comb;

    // Operand capture: this is the "sample" edge of the core latency.
    always_ff @(posedge clk) begin
        a_q <= FP_A;
        b_q <= FP_B;
    end

    // Whole multiply in one combinational step; the remaining latency is a
    // plain delay line, which keeps timing retiming-friendly.
    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        prod   = {24'd0, 1'b1, a_q[22:0]} * {24'd0, 1'b1, b_q[22:0]};
        // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the
        // normalisation shift.
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
               + $signed({9'd0, prod[47]});
        frac_r = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
        // Rounding carry out of the mantissa leaves frac_r[22:0] at zero,
        // so only the exponent needs bumping.
        if (frac_r[23]) begin
            exp_s = exp_s + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            z_comb = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            z_comb = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            z_comb = {sign, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            z_comb = {sign, 8'hFF, 23'd0};
        end else if (exp_s <= 10'sd0) begin
            z_comb = {sign, 31'd0};
        end else begin
            z_comb = {sign, exp_s[7:0], frac_r[22:0]};
        end
    end

    generate
        if (LAT == 1) begin : g_direct
            assign FP_Z = z_comb;
        end else begin : g_delay
            logic [31:0] z_pipe [LAT-1];
            always_ff @(posedge clk) begin
                z_pipe[0] <= z_comb;
                for (int i = 1; i < LAT - 1; i++) begin
                    z_pipe[i] <= z_pipe[i-1];
                end
            end
            assign FP_Z = z_pipe[LAT-2];
        end
    endgenerate

endmodule

// File: rtl/fpmul_stream_fifo.sv
// fpmul_stream_fifo
// First-word-fall-through result buffer. rd_data always shows the head entry,
// so it stays put while the consumer stalls. Pointers wrap modulo DEPTH, which
// need not be a power of two.
// Ports:
//   clk, rst : clock, synchronous active-high reset (empties the buffer)
//   wr_en    : push wr_data this edge
//   wr_data  : entry to push
//   rd_en    : pop the head entry this edge
//   rd_data  : head entry (meaningless while empty)
//   empty    : no entries held
module fpmul_stream_fifo
    import fpmul_stream_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = result_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   wr_en,
    input  entry_t wr_data,
    input  logic   rd_en,
    output entry_t rd_data,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // The upstream credit counter never lets the pipeline hold more results
    // than there is free space, so these can only fire on a design bug.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(wr_en && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && empty));

endmodule

// File: rtl/fpmul_stream.sv
// fpmul_stream
// Valid/ready streaming wrapper around the no-stall FPmul core. A credit count
// (inflight) covers results both in the core and in the output buffer, so an
// operation is accepted only when a buffer slot is guaranteed for its result.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake
//   in_a, in_b, in_tag   : operands and user tag
//   out_valid / out_ready: result handshake
//   out_z, out_tag       : product and tag of the head result
//   inflight             : operations accepted but not yet transferred
module fpmul_stream
    import fpmul_stream_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAGW  = DEF_TAGW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_z,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int             IW        = $clog2(DEPTH + 1);
    localparam logic [IW-1:0]  DEPTH_CNT = IW'(DEPTH);

    generate
        if (W != 32) begin : g_w_check
            $error("fpmul_stream: W must be 32 for the single-precision core");
        end
        if (TAGW != DEF_TAGW) begin : g_tagw_check
            $error("fpmul_stream: TAGW must match the package result_t");
        end
        if (DEPTH < LAT + 1) begin : g_depth_check
            $error("fpmul_stream: DEPTH must be at least LAT+1");
        end
    endgenerate

    logic [IW-1:0]   count;
    logic [LAT-1:0]  valid_sr;
    logic [TAGW-1:0] tag_sr [LAT];
    logic [W-1:0]    core_z;
    logic            accept;
    logic            xfer;
    logic            buf_empty;
    result_t         wr_data;
    result_t         rd_data;

    assign in_ready  = (count < DEPTH_CNT) && !rst;
    assign out_valid = !buf_empty && !rst;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign inflight  = rst ? '0 : count;

    // Credit count plus the valid shift register that marks which core
    // outputs belong to accepted operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            valid_sr <= '0;
        end else begin
            valid_sr <= (valid_sr << 1) | LAT'(accept);
            unique case ({accept, xfer})
                2'b10:   count <= count + IW'(1);
                2'b01:   count <= count - IW'(1);
                default: ;
            endcase
        end
    end

    // Tags travel beside the core; entries not marked valid are ignored,
    // so this line needs no reset.
    always_ff @(posedge clk) begin
        tag_sr[0] <= in_tag;
        for (int i = 1; i < LAT; i++) begin
            tag_sr[i] <= tag_sr[i-1];
        end
    end

    FPmul #(
        .LAT (LAT)
    ) u_core (
        .clk  (clk),
        .FP_A (in_a),
        .FP_B (in_b),
        .FP_Z (core_z)
    );

    assign wr_data = '{z: core_z, tag: tag_sr[LAT-1]};

    fpmul_stream_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (result_t)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (valid_sr[LAT-1]),
        .wr_data (wr_data),
        .rd_en   (xfer),
        .rd_data (rd_data),
        .empty   (buf_empty)
    );

    assign out_z   = rd_data.z;
    assign out_tag = rd_data.tag;

endmodule

// File: tb/tb_fpmul_stream.sv
// tb_fpmul_stream
// Self-checking bench for fpmul_stream. A queue of expected results (product
// computed through double-precision arithmetic, tag, and the cycle from which
// the result must be visible) is compared against the DUT on every falling edge.
module tb_fpmul_stream;

    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [3:0]  out_tag;
    logic [3:0]  inflight;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        int          ready_at;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_log[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_count = 0;
    int   xfer_count = 0;
    int   max_inflight = 0;

    fpmul_stream #(
        .W     (32),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .TAGW  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Single-precision product via exact double multiply, then RNE rounding
    // of the 52-bit fraction down to 23 bits. Valid for normal operands whose
    // product stays in the normal range, and for zero operands.
    function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
        real         da, db, p;
        logic [63:0] bits;
        logic [22:0] m;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            return {a[31] ^ b[31], 31'd0};
        end
        da   = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
        db   = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
        p    = da * db;
        bits = $realtobits(p);
        e    = int'(bits[62:52]) - 896;
        m    = bits[51:29];
        if (bits[28] && ((|bits[27:0]) || m[0])) begin
            m = m + 23'd1;
            if (m == 23'd0) e++;
        end
        return {bits[63], e[7:0], m};
    endfunction

    function automatic logic [31:0] randNormal();
        logic [7:0] e;
        e = 8'($urandom_range(64, 190));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected-result queue, then queue
    // update for the transfer and accept about to happen on the next edge.
    task automatic checkOutput();
        exp_t e;
        bit   exp_ready;
        bit   exp_ov;
        exp_ready = (exp_q.size() < DEPTH);
        exp_ov    = (exp_q.size() > 0) && (cyc >= exp_q[0].ready_at);
        expectEq("in_ready", in_ready, exp_ready);
        expectEq("inflight", inflight, exp_q.size());
        expectEq("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            expectEq("out_z", out_z, exp_q[0].z);
            expectEq("out_tag", out_tag, exp_q[0].tag);
        end
        if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
        if (exp_ov && out_ready) begin
            void'(exp_q.pop_front());
            xfer_log.push_back(cyc);
            xfer_count++;
        end
        if (in_valid && exp_ready) begin
            e.z        = modelMul(in_a, in_b);
            e.tag      = in_tag;
            e.ready_at = cyc + 1 + LAT;
            exp_q.push_back(e);
            acc_count++;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expectEq("rst out_valid", out_valid, 0);
            expectEq("rst in_ready", in_ready, 0);
            expectEq("rst inflight", inflight, 0);
            exp_q.delete();
        end else begin
            checkOutput();
        end
    end

    // Drive one cycle of inputs, let the edge pass, return 1 time unit later.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            n++;
        end
        expectEq({name, " drained"}, exp_q.size(), 0);
    endtask

    task automatic singleOp(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [31:0] want);
        int n;
        applyStimulus(1'b1, a, b, tag, 1'b1);
        n = 1;
        while (!out_valid && n < 20) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            n++;
        end
        expectEq({name, " latency"}, n, LAT + 1);
        expectEq({name, " out_z"}, out_z, want);
        expectEq({name, " out_tag"}, out_tag, tag);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0, x0, r;

        // Model pins, hand-computed.
        expectEq("model 1.5x2.0", modelMul(32'h3FC00000, 32'h40000000), 32'h40400000);
        expectEq("model 3x3", modelMul(32'h40400000, 32'h40400000), 32'h41100000);
        expectEq("model -1x2", modelMul(32'hBF800000, 32'h40000000), 32'hC0000000);
        expectEq("model sticky", modelMul(32'h3F800001, 32'h3F800001), 32'h3F800002);
        expectEq("model tie odd", modelMul(32'h3F800001, 32'h3FC00000), 32'h3FC00002);
        expectEq("model tie even", modelMul(32'h3F800003, 32'h3FC00000), 32'h3FC00004);
        expectEq("model zero", modelMul(32'h00000000, 32'h40A00000), 32'h00000000);

        // Reset state and release.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expectEq("reset in_ready", in_ready, 0);
        expectEq("reset out_valid", out_valid, 0);
        expectEq("reset inflight", inflight, 0);
        rst = 1'b0;
        #1;
        expectEq("release in_ready", in_ready, 1);

        $display("[TB] single operation");
        singleOp("single", 32'h3FC00000, 32'h40000000, 4'd3, 32'h40400000);
        singleOp("zero", 32'h00000000, 32'h40A00000, 4'd9, 32'h00000000);
        singleOp("round", 32'h3F800001, 32'h3FC00000, 4'd5, 32'h3FC00002);

        $display("[TB] streaming");
        xfer_log.delete();
        max_inflight = 0;
        a0 = acc_count;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, randNormal(), randNormal(), 4'(i), 1'b1);
        end
        drain("stream");
        expectEq("stream accepts", acc_count - a0, 16);
        expectEq("stream results", xfer_log.size(), 16);
        if (xfer_log.size() == 16) begin
            expectEq("stream back-to-back", xfer_log[15] - xfer_log[0], 15);
        end
        expectEq("stream max inflight ok", max_inflight <= LAT + 1, 1);

        $display("[TB] backpressure");
        a0 = acc_count;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, randNormal(), randNormal(), 4'(i), 1'b0);
        end
        expectEq("bp accepts", acc_count - a0, DEPTH);
        expectEq("bp in_ready", in_ready, 0);
        expectEq("bp inflight", inflight, DEPTH);
        expectEq("bp out_valid", out_valid, 1);
        in_valid  = 1'b1;
        in_a      = randNormal();
        in_b      = randNormal();
        in_tag    = 4'd12;
        out_ready = 1'b1;
        #1;
        expectEq("full in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        expectEq("after xfer in_ready", in_ready, 1);
        expectEq("after xfer inflight", inflight, DEPTH - 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, randNormal(), randNormal(), 4'(13 + i), 1'b1);
            expectEq("boundary inflight", inflight, DEPTH - 1);
        end
        drain("bp");
        expectEq("bp end in_ready", in_ready, 1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, randNormal(), randNormal(), 4'(i), 1'b0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        expectEq("mid rst out_valid", out_valid, 0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        rst = 1'b0;
        #1;
        expectEq("post rst in_ready", in_ready, 1);
        x0 = xfer_count;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
        end
        expectEq("post rst no stale", out_valid, 0);
        expectEq("post rst transfers", xfer_count - x0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = randNormal();
            b = randNormal();
            r = $urandom_range(0, 15);
            if (r == 0) a = {a[31], 31'd0};
            if (r == 1) b = {b[31], 31'd0};
            applyStimulus($urandom_range(0, 9) < 7, a, b, 4'($urandom), $urandom_range(0, 9) < 6);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
